// File: rtl/alu_op_driver.sv
// alu_op_driver: initiator-side front end for the floating-point ALU.
// Takes operand/opcode requests on a valid/ready channel, drives the ALU
// inputs from registers, waits ALU_LATENCY edges, then captures the ALU
// result and presents it on a valid/ready output channel.
// Optional feature macro: ALU_OP_DRIVER_FLAGS_EN adds out_flags[3:0] =
// {nan, inf, zero, neg}, classified from alu_o at capture time.
module alu_op_driver #(
  parameter int ALU_LATENCY = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [1:0]       in_op,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [1:0]       alu_op,
  input  logic [31:0]      alu_o,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [1:0]       out_op,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
`ifdef ALU_OP_DRIVER_FLAGS_EN
  ,
  output logic [3:0]       out_flags
`endif
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] WAIT = 2'b01;
  localparam logic [1:0] HOLD = 2'b10;

  // Wait counter load value; ALU_LATENCY is limited to 1..15 so 4 bits suffice.
  localparam logic [3:0]       LAT_LOAD  = 4'(ALU_LATENCY);
  localparam logic [CNT_W-1:0] COUNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef ALU_OP_DRIVER_FLAGS_EN
  // Classify a single-precision value as {nan, inf, zero, neg}.
  function automatic logic [3:0] fpFlags(input logic [31:0] v);
    logic expAll;
    logic expZero;
    logic manZero;
    expAll  = (v[30:23] == 8'hFF);
    expZero = (v[30:23] == 8'h00);
    manZero = (v[22:0] == 23'd0);
    fpFlags = {expAll & ~manZero, expAll & manZero, expZero & manZero, v[31]};
  endfunction
`endif

  logic [1:0] stateR;
  logic [1:0] nextStateS;
  logic [3:0] cntR;
  logic       acceptS;
  logic       handshakeS;
  logic       captureS;

  // Request-side ready decode: free in IDLE, or in HOLD when the result drains this edge.
  always_comb begin
    in_ready = 1'b0;
    case (stateR)
      IDLE:    in_ready = 1'b1;
      HOLD:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  assign acceptS    = in_valid & in_ready;
  assign handshakeS = (stateR == HOLD) & out_ready;
  assign captureS   = (stateR == WAIT) & (cntR == 4'd0);
  assign busy       = (stateR != IDLE);

  // Next-state selection; a drain with a simultaneous accept goes straight back to WAIT.
  always_comb begin
    nextStateS = stateR;
    case (stateR)
      IDLE: begin
        if (acceptS) nextStateS = WAIT;
        else         nextStateS = IDLE;
      end
      WAIT: begin
        if (cntR == 4'd0) nextStateS = HOLD;
        else              nextStateS = WAIT;
      end
      HOLD: begin
        if (handshakeS) begin
          if (acceptS) nextStateS = WAIT;
          else         nextStateS = IDLE;
        end else begin
          nextStateS = HOLD;
        end
      end
      default: nextStateS = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stateR <= IDLE;
    else        stateR <= nextStateS;
  end

  // Latency counter: loaded on accept, counts down to zero while waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cntR <= 4'd0;
    end else if (acceptS) begin
      cntR <= LAT_LOAD;
    end else if ((stateR == WAIT) && (cntR != 4'd0)) begin
      cntR <= cntR - 4'd1;
    end
  end

  // ALU operand registers: updated only on accept, otherwise keep their last values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a  <= 32'd0;
      alu_b  <= 32'd0;
      alu_op <= 2'b00;
    end else if (acceptS) begin
      alu_a  <= in_a;
      alu_b  <= in_b;
      alu_op <= in_op;
    end
  end

  // Result capture: alu_o is passed through bit-exact once the latency has elapsed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_result <= 32'd0;
      out_op     <= 2'b00;
    end else if (captureS) begin
      out_result <= alu_o;
      out_op     <= alu_op;
    end
  end

`ifdef ALU_OP_DRIVER_FLAGS_EN
  // Result classification flags, captured on the same edge as out_result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        out_flags <= 4'b0000;
    else if (captureS) out_flags <= fpFlags(alu_o);
  end
`endif

  // Output valid: set on capture, cleared by the consumer handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          out_valid <= 1'b0;
    else if (captureS)   out_valid <= 1'b1;
    else if (handshakeS) out_valid <= 1'b0;
  end

  // Completed-operation counter, wraps naturally from all-ones to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          op_count <= {CNT_W{1'b0}};
    else if (handshakeS) op_count <= op_count + COUNT_ONE;
  end

endmodule

// File: tb/tb_alu_op_driver.sv
// Self-checking bench for alu_op_driver: a stand-in ALU with a fixed
// pipeline latency plus a transaction-level reference model of the driver.
module tb_alu_op_driver;

  localparam int LAT = 3;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_a = 32'd0;
  logic [31:0]   in_b = 32'd0;
  logic [1:0]    in_op = 2'b00;
  logic [31:0]   alu_a;
  logic [31:0]   alu_b;
  logic [1:0]    alu_op;
  logic [31:0]   alu_o;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_result;
  logic [1:0]    out_op;
  logic          busy;
  logic [CW-1:0] op_count;
`ifdef ALU_OP_DRIVER_FLAGS_EN
  logic [3:0]    out_flags;
`endif

  always #5 clk = ~clk;

  alu_op_driver #(.ALU_LATENCY(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_o(alu_o),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_op(out_op),
    .busy(busy), .op_count(op_count)
`ifdef ALU_OP_DRIVER_FLAGS_EN
    , .out_flags(out_flags)
`endif
  );

  // Stand-in ALU: known IEEE results for the directed cases, a scramble otherwise.
  function automatic logic [31:0] aluFn(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    if (a == 32'h3F800000 && b == 32'h40000000 && op == 2'b00) return 32'h40400000;
    if (a == 32'h40000000 && b == 32'h40400000 && op == 2'b11) return 32'h40C00000;
    if (a == 32'h3F800000 && b == 32'h00000000 && op == 2'b11) return 32'h00000000;
    if (a == 32'h7FC00000 && b == 32'h3F800000 && op == 2'b00) return 32'h7FC00000;
    if (b == 32'd0 && op == 2'b00) return a;
    return a ^ {b[15:0], b[31:16]} ^ {30'd0, op};
  endfunction

  // Expected {nan, inf, zero, neg} from plain field arithmetic.
  function automatic logic [3:0] flagsOf(input logic [31:0] r);
    int unsigned e;
    int unsigned m;
    e = (r >> 23) & 32'hFF;
    m = r & 32'h007FFFFF;
    return {(e == 255 && m != 0), (e == 255 && m == 0), (e == 0 && m == 0), r[31]};
  endfunction

  // ALU pipeline: alu_o reflects the inputs LAT edges after they change.
  logic [31:0] aluPipe [LAT];
  assign alu_o = aluPipe[LAT-1];
  always @(posedge clk) begin
    aluPipe[0] <= aluFn(alu_a, alu_b, alu_op);
    for (int i = 1; i < LAT; i++) aluPipe[i] <= aluPipe[i-1];
  end

  int checks = 0;
  int errors = 0;

  // Reference model state (transaction level).
  bit          haveTx = 1'b0;
  int          acceptCyc = 0;
  int          cyc = 0;
  int          doneCnt = 0;
  logic [31:0] expRes = 32'd0;
  logic [1:0]  expOp = 2'b00;
  logic [31:0] lastA = 32'd0;
  logic [31:0] lastB = 32'd0;
  logic [1:0]  lastOp = 2'b00;

  function automatic bit modelValid();
    return haveTx && (cyc >= acceptCyc + LAT + 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutputs();
    chk("busy", 32'(busy), 32'(haveTx));
    chk("out_valid", 32'(out_valid), 32'(modelValid()));
    chk("op_count", 32'(op_count), 32'(doneCnt % (1 << CW)));
    chk("alu_a", alu_a, lastA);
    chk("alu_b", alu_b, lastB);
    chk("alu_op", 32'(alu_op), 32'(lastOp));
    if (modelValid()) begin
      chk("out_result", out_result, expRes);
      chk("out_op", 32'(out_op), 32'(expOp));
`ifdef ALU_OP_DRIVER_FLAGS_EN
      chk("out_flags", 32'(out_flags), 32'(flagsOf(expRes)));
`endif
    end
  endtask

  // One clock of stimulus; starts and ends 1 time unit after a rising edge.
  task automatic step(input bit iv, input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] op, input bit ordy);
    bit vBefore;
    bit rdyExp;
    in_valid = iv; in_a = a; in_b = b; in_op = op; out_ready = ordy;
    #1;
    vBefore = modelValid();
    rdyExp  = !haveTx || (vBefore && ordy);
    chk("in_ready", 32'(in_ready), 32'(rdyExp));
    @(posedge clk);
    cyc++;
    if (vBefore && ordy) begin
      haveTx = 1'b0;
      doneCnt++;
    end
    if (iv && rdyExp) begin
      haveTx = 1'b1; acceptCyc = cyc;
      expRes = aluFn(a, b, op); expOp = op;
      lastA = a; lastB = b; lastOp = op;
    end
    #1;
    checkOutputs();
  endtask

  // Run with out_ready high until the outstanding transaction has drained.
  task automatic drain();
    for (int i = 0; i < LAT + 6; i++) begin
      if (haveTx) step(1'b0, 32'd0, 32'd0, 2'b00, 1'b1);
    end
    chk("drain_done", 32'(haveTx), 32'd0);
  endtask

  function automatic logic [31:0] pickA();
    case ($urandom_range(0, 7))
      0: return 32'h7F800000;
      1: return 32'hFF800000;
      2: return 32'h7FC00001;
      3: return 32'h80000000;
      4: return 32'h00000000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_op", 32'(out_op), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
`ifdef ALU_OP_DRIVER_FLAGS_EN
    chk("rst_out_flags", 32'(out_flags), 32'd0);
`endif
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // ADD 1.0 + 2.0
    step(1'b1, 32'h3F800000, 32'h40000000, 2'b00, 1'b1);
    drain();

    // Backpressure: result held while out_ready low, new requests refused
    step(1'b1, 32'h3F800000, 32'h40000000, 2'b00, 1'b0);
    for (int i = 0; i < LAT + 6; i++) step(1'b1, $urandom, $urandom, 2'b10, 1'b0);
    step(1'b0, 32'd0, 32'd0, 2'b00, 1'b1);

    // Overlap: drain and accept MUL 2.0 * 3.0 on the same edge
    step(1'b1, 32'h3F800000, 32'h40000000, 2'b00, 1'b0);
    for (int i = 0; i < LAT + 2; i++) begin
      if (!modelValid()) step(1'b0, 32'd0, 32'd0, 2'b00, 1'b0);
    end
    step(1'b1, 32'h40000000, 32'h40400000, 2'b11, 1'b1);
    chk("overlap_busy", 32'(busy), 32'd1);
    drain();
    chk("mul_result_seen", expRes, 32'h40C00000);

    // Special results: zero and NaN
    step(1'b1, 32'h3F800000, 32'h00000000, 2'b11, 1'b1);
    drain();
    step(1'b1, 32'h7FC00000, 32'h3F800000, 2'b00, 1'b1);
    drain();

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, pickA(),
           ($urandom_range(0, 1) != 0) ? 32'd0 : $urandom,
           2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
    end
    drain();

    // Counter wrap: complete operations up to a multiple of 16
    for (int i = 0; i < 16; i++) begin
      if (doneCnt % 16 != 0) begin
        step(1'b1, $urandom, $urandom, 2'b01, 1'b1);
        drain();
      end
    end
    chk("op_count_wrap", 32'(op_count), 32'd0);

    // Reset in WAIT abandons the request
    step(1'b1, 32'h12345678, 32'h0BADF00D, 2'b10, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_op_count", 32'(op_count), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    haveTx = 1'b0; doneCnt = 0;
    lastA = 32'd0; lastB = 32'd0; lastOp = 2'b00;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < LAT + 4; i++) step(1'b0, 32'd0, 32'd0, 2'b00, 1'b1);
    step(1'b1, 32'h3F800000, 32'h40000000, 2'b00, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
